// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_stage : single-outstanding instruction fetch feeding the IQ, rev 1.0 |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h1eceb000,
  parameter int unsigned     IQ_WIDTH = 2*XLEN
) (
  input  logic                clk,
  input  logic                rst,
  output logic [XLEN-1:0]     imem_addr,
  output logic [3:0]          imem_rmask,
  input  logic [XLEN-1:0]     imem_rdata,
  input  logic                imem_resp,
  output logic                iq_enq,
  output logic [IQ_WIDTH-1:0] iq_d_in,
  input  logic                iq_full,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  output logic                iq_flush,
  output logic [31:0]         fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     fetch_count_q;

  logic [XLEN-1:0] redir_pc;
  logic            req;
  logic            accept;

  assign redir_pc = redirect_pc & ~XLEN'(3);
  assign req      = !rst && (state_q == S_IDLE) && !redirect_valid && !iq_full;
  // A redirect in the response cycle squashes the word, so it never reaches the IQ.
  assign accept   = !rst && (state_q == S_WAIT) && imem_resp && !redirect_valid;

  assign imem_addr   = pc_q;
  assign imem_rmask  = req ? 4'hF : 4'h0;
  assign iq_enq      = accept;
  assign iq_d_in     = rst ? '0 : {pc_q, imem_rdata};
  assign iq_flush    = redirect_valid & ~rst;
  assign fetch_count = fetch_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end else if (!iq_full) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp) begin
            state_q <= S_IDLE;
            if (redirect_valid) begin
              pc_q <= redir_pc;
            end else begin
              pc_q          <= pc_q + XLEN'(4);
              fetch_count_q <= fetch_count_q + 32'd1;
            end
          end else if (redirect_valid) begin
            pc_q    <= redir_pc;
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          // The squashed fetch still owes a response; no new request until it lands.
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end
          if (imem_resp) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_stage : scoreboard + vector-table bench for fetch_stage, rev 1.0  |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        iq_enq;
  logic [63:0] iq_d_in;
  logic        iq_full;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        iq_flush;
  logic [31:0] fetch_count;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_rmask     (imem_rmask),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .iq_enq         (iq_enq),
    .iq_d_in        (iq_d_in),
    .iq_full        (iq_full),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .iq_flush       (iq_flush),
    .fetch_count    (fetch_count)
  );

  int          passed = 0;
  int          total = 0;
  logic [63:0] sb[$];
  int          exp_count = 0;
  logic        g_rst = 1'b1;
  logic        g_full = 1'b0;
  int          mem_lat = 1;
  bit          mem_keep = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_pend = '0;
  int          enqs = 0;
  int          reqs = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], 16'h0013};
  endfunction

  // Memory model: latency mem_lat cycles from request cycle to response pulse.
  initial begin
    logic        m_req;
    logic [31:0] m_addr;
    logic        m_rst;
    imem_resp  = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      m_req  = (imem_rmask == 4'hF);
      m_addr = imem_addr;
      m_rst  = rst;
      @(posedge clk);
      #1;
      imem_resp = 1'b0;
      if (m_rst && !mem_keep) begin
        mem_cnt = 0;
      end else begin
        if (m_req) begin
          mem_cnt  = mem_lat;
          mem_pend = m_addr;
        end
        if (mem_cnt > 0) begin
          mem_cnt = mem_cnt - 1;
          if (mem_cnt == 0) begin
            imem_resp  = 1'b1;
            imem_rdata = mem_word(mem_pend);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // One clock: drive inputs just after posedge, observe at negedge.
  task automatic cyc(input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #2;
    rst            = g_rst;
    iq_full        = g_full;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk);
    if (imem_rmask == 4'hF) begin
      reqs++;
      chk("one_outstanding", mem_cnt, 0);
    end
    if (iq_enq) begin
      enqs++;
      if (sb.size() == 0) chk("enq_unexpected", iq_enq, 0);
      else chk("enq_data", iq_d_in, sb.pop_front());
    end
  endtask

  task automatic fetch(input logic [31:0] a);
    bit got = 1'b0;
    cyc(1'b0, '0);
    chk("req_mask", imem_rmask, 4'hF);
    chk("req_addr", imem_addr, a);
    sb.push_back({a, mem_word(a)});
    exp_count++;
    for (int i = 0; i < 8 && !got; i++) begin
      cyc(1'b0, '0);
      got = iq_enq;
    end
    chk("enq_timeout", got, 1);
  endtask

  task automatic do_reset();
    g_rst = 1'b1;
    cyc(1'b1, 32'hdeadbeef);
    chk("rst_mask", imem_rmask, 0);
    chk("rst_enq", iq_enq, 0);
    chk("rst_flush", iq_flush, 0);
    chk("rst_din", iq_d_in, 0);
    cyc(1'b0, '0);
    chk("rst_pc", imem_addr, RPC);
    chk("rst_count", fetch_count, 0);
    g_rst = 1'b0;
    sb.delete();
    exp_count = 0;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] req;
    logic [31:0] nxt;
  } vec_t;

  initial begin
    vec_t        vt[4];
    int          occ;
    logic [31:0] exp_pc;

    vt[0] = '{rpc: 32'h1eceb103, req: 32'h1eceb100, nxt: 32'h1eceb104};
    vt[1] = '{rpc: 32'h00000002, req: 32'h00000000, nxt: 32'h00000004};
    vt[2] = '{rpc: 32'hffffffff, req: 32'hfffffffc, nxt: 32'h00000000};
    vt[3] = '{rpc: 32'h80000005, req: 32'h80000004, nxt: 32'h80000008};

    rst = 1'b1; iq_full = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // Back-to-back fetches, 1-cycle memory
    do_reset();
    for (int i = 0; i < 3; i++) fetch(RPC + 32'(4 * i));
    g_full = 1'b1;
    cyc(1'b0, '0);
    chk("count_after3", fetch_count, exp_count);
    chk("full_no_req", imem_rmask, 0);

    // Queue full from reset, then release; full rising in WAIT keeps the enqueue
    do_reset();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, '0);
      chk("full_hold_mask", imem_rmask, 0);
      chk("full_hold_pc", imem_addr, RPC);
    end
    g_full = 1'b0;
    cyc(1'b0, '0);
    chk("release_mask", imem_rmask, 4'hF);
    chk("release_addr", imem_addr, RPC);
    sb.push_back({RPC, mem_word(RPC)});
    exp_count++;
    g_full = 1'b1;
    cyc(1'b0, '0);
    chk("enq_despite_full", iq_enq, 1);
    g_full = 1'b0;

    // Redirect during WAIT with 3-cycle memory: stale response must be dropped
    mem_lat = 3;
    cyc(1'b0, '0);
    chk("t3_req_addr", imem_addr, RPC + 32'd4);
    cyc(1'b1, 32'h1eceb103);
    chk("t3_flush", iq_flush, 1);
    chk("t3_no_enq", iq_enq, 0);
    cyc(1'b0, '0);
    chk("t3_flush_clear", iq_flush, 0);
    chk("t3_drop_no_req", imem_rmask, 0);
    cyc(1'b0, '0);
    chk("t3_stale_resp", imem_resp, 1);
    chk("t3_stale_dropped", iq_enq, 0);
    chk("t3_drop_no_req2", imem_rmask, 0);
    fetch(32'h1eceb100);

    // Redirect coincident with the response
    mem_lat = 1;
    cyc(1'b0, '0);
    chk("t4_req_addr", imem_addr, 32'h1eceb104);
    cyc(1'b1, 32'h1eceb2f0);
    chk("t4_resp", imem_resp, 1);
    chk("t4_no_enq", iq_enq, 0);
    chk("t4_flush", iq_flush, 1);
    fetch(32'h1eceb2f0);
    g_full = 1'b1;
    cyc(1'b0, '0);
    chk("t4_count", fetch_count, exp_count);

    // Fill an 8-deep queue, then free one slot
    occ = 0; enqs = 0; reqs = 0; exp_pc = 32'h1eceb2f4;
    for (int i = 0; i < 40; i++) begin
      g_full = (occ >= 8);
      cyc(1'b0, '0);
      if (imem_rmask == 4'hF) begin
        chk("fill_addr", imem_addr, exp_pc);
        sb.push_back({exp_pc, mem_word(exp_pc)});
        exp_count++;
        exp_pc += 32'd4;
      end
      if (iq_enq) occ++;
    end
    chk("fill_enqs", enqs, 8);
    chk("fill_reqs", reqs, 8);
    occ = 7;
    for (int i = 0; i < 10; i++) begin
      g_full = (occ >= 8);
      cyc(1'b0, '0);
      if (imem_rmask == 4'hF) begin
        chk("deq_addr", imem_addr, exp_pc);
        sb.push_back({exp_pc, mem_word(exp_pc)});
        exp_count++;
        exp_pc += 32'd4;
      end
      if (iq_enq) occ++;
    end
    chk("deq_enqs", enqs, 9);
    chk("deq_reqs", reqs, 9);

    // Redirect vectors from IDLE: alignment and PC wrap
    g_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, vt[i].rpc);
      chk("vec_flush", iq_flush, 1);
      chk("vec_no_req", imem_rmask, 0);
      fetch(vt[i].req);
      fetch(vt[i].nxt);
    end
    g_full = 1'b1;
    cyc(1'b0, '0);
    chk("vec_count", fetch_count, exp_count);

    // Reset while in WAIT at 1eceb010; late response lands in IDLE
    g_full = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) fetch(RPC + 32'(4 * i));
    mem_lat = 3; mem_keep = 1'b1;
    cyc(1'b0, '0);
    chk("t7_req_addr", imem_addr, 32'h1eceb010);
    g_rst = 1'b1; g_full = 1'b1;
    cyc(1'b0, '0);
    chk("t7_rst_enq", iq_enq, 0);
    chk("t7_rst_mask", imem_rmask, 0);
    g_rst = 1'b0;
    exp_count = 0;
    cyc(1'b0, '0);
    chk("t7_pc", imem_addr, RPC);
    chk("t7_count", fetch_count, exp_count);
    cyc(1'b0, '0);
    chk("t7_late_resp", imem_resp, 1);
    chk("t7_late_ignored", iq_enq, 0);
    mem_keep = 1'b0; mem_lat = 1; g_full = 1'b0;
    fetch(RPC);
    g_full = 1'b1;
    cyc(1'b0, '0);
    chk("t7_count_after", fetch_count, exp_count);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
